aib_rx_word_aligner: RTL and testbench
======================================

AIB_RX_WORD_ALIGNER -- requirements
Module: aib_rx_word_aligner

Interface
REQ-001 SHALL have parameter WORD_W, default 20, word width in bits; SHALL be even and at least 4.
REQ-002 SHALL have parameter LOCK_CNT, default 4, number of consecutive marker hits needed to declare lock; range 1 to 15.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: i_clk for the clock and i_rst_n for the reset.
REQ-004 i_clk  input  1  Rx retime clock; samples the DDR bit pair.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 c_align_en  input  1  static enable; low forces IDLE.
REQ-007 c_marker  input  WORD_W  static alignment marker word.
REQ-008 i_realign  input  1  single-cycle pulse; drops lock and restarts the hunt.
REQ-009 i_rx_data0  input  1  earlier bit of the pair (negedge-sampled, retimed).
REQ-010 i_rx_data1  input  1  later bit of the pair (posedge-sampled, retimed).
REQ-011 o_data  output  WORD_W  aligned word; bit 0 is the oldest received bit.
REQ-012 o_valid  output  1  one-cycle strobe marking each aligned word.
REQ-013 o_locked  output  1  high while in LOCKED.
REQ-014 o_bit_slip  output  1  locked offset: 0 = word starts on a data0 bit, 1 = word starts on a data1 bit.

Function
REQ-015 SHALL shift in 2 bits per cycle in stream order (data0, then data1) into a history of at least WORD_W+1 bits.
REQ-016 Even window SHALL be the last WORD_W bits ending at the current data1; odd window SHALL be the last WORD_W bits ending at the current data0.
REQ-017 FSM states: IDLE, HUNT, VERIFY, LOCKED.
REQ-018 IDLE: enter HUNT on the cycle after c_align_en is seen high.
REQ-019 HUNT: compare both windows to c_marker every cycle.
- On a match: latch the offset, clear the phase counter, set the hit count to 1, and enter VERIFY; if LOCK_CNT=1, enter LOCKED directly.
- If both windows match, the even window SHALL win.
REQ-020 Phase counter SHALL count modulo WORD_W/2 and wrap to 0 after WORD_W/2-1.
- Word boundary = a cycle where the counter equals WORD_W/2-1.
REQ-021 VERIFY: at each word boundary, compare the latched-offset window to c_marker.
- Hit: increment the hit count; when it reaches LOCK_CNT, enter LOCKED.
- Miss: return to HUNT and clear the hit count.
REQ-022 LOCKED: at each word boundary, register the latched-offset window into o_data and pulse o_valid high for exactly one cycle.
- Latency: 1 cycle after the cycle that completes the word.
REQ-023 LOCKED SHALL exit to HUNT on i_realign; o_locked and o_valid SHALL be low from the next cycle.
REQ-024 c_align_en low SHALL force IDLE from any state on the next cycle.
- IDLE clears the hit count and phase counter and drives o_locked and o_valid low.
REQ-025 i_realign in HUNT or VERIFY SHALL restart HUNT; i_realign together with c_align_en low SHALL resolve to IDLE.
REQ-026 o_data SHALL hold its last value when o_valid is low.

Reset
REQ-027 On reset assertion: state = IDLE; history, o_data, o_valid, o_locked, o_bit_slip, counters = 0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; no o_valid SHALL follow the release of reset until a new lock.

Configuration
REQ-029 Macro AIB_RX_ALIGN_RELOCK_CNT_EN defined: an output port o_relock_cnt [7:0] SHALL count LOCKED exits (i_realign or c_align_en low).
- Counts with saturation at 255; reset value 0.
REQ-030 Macro undefined: o_relock_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package aib_rx_align_pkg SHALL hold the FSM state enum and the default constants AIB_RX_WORD_W=20 and AIB_RX_LOCK_CNT=4.
REQ-032 Sub-module aib_rx_marker_match SHALL be purely combinational: even/odd window vs marker compare, producing even_hit and odd_hit.

Verification
REQ-033 With WORD_W=20, LOCK_CNT=4, c_marker=20'h3C5A7, the bench SHALL cover these scenarios:
- Marker stream at even offset: o_locked rises 1 cycle after the 4th hit, o_bit_slip=0, then o_valid fires every 10 cycles with o_data=20'h3C5A7.
- Stream delayed by 1 bit: lock with o_bit_slip=1; subsequent words 20'h12345 and 20'hABCDE appear intact on o_data.
- Corrupt the 3rd marker: state returns to HUNT; lock asserts only after 4 fresh consecutive hits.
- i_realign pulse in LOCKED: o_locked low next cycle, relock follows; with AIB_RX_ALIGN_RELOCK_CNT_EN, o_relock_cnt=1.
- i_rst_n asserted mid-word in LOCKED: all outputs 0 immediately; no o_valid before relock.
- Both windows equal the marker (marker 20'hFFFFF, all-ones stream): even offset chosen, o_bit_slip=0.

Source files
------------

// File: rtl/aib_rx_align_pkg.sv
// Shared definitions for the AIB receive word aligner: FSM state encoding
// and the default word width / lock threshold.
package aib_rx_align_pkg;

    localparam int AIB_RX_WORD_W   = 20;
    localparam int AIB_RX_LOCK_CNT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_t;

endpackage

// File: rtl/aib_rx_marker_match.sv
// Combinational marker comparator. The window holds WORD_W+1 stream bits
// (bit 0 oldest, MSB = current data1). The even candidate is the upper
// WORD_W bits (ending at data1), the odd candidate the lower WORD_W bits
// (ending at data0).
module aib_rx_marker_match
    import aib_rx_align_pkg::*;
#(
    parameter int WORD_W = AIB_RX_WORD_W
) (
    input  logic [WORD_W:0]   window,
    input  logic [WORD_W-1:0] marker,
    output logic              even_hit,
    output logic              odd_hit
);

    logic [WORD_W-1:0] even_eq;
    logic [WORD_W-1:0] odd_eq;

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit_eq
            assign even_eq[gi] = window[gi+1] ~^ marker[gi];
            assign odd_eq[gi]  = window[gi]   ~^ marker[gi];
        end
    endgenerate

    assign even_hit = &even_eq;
    assign odd_hit  = &odd_eq;

endmodule

// File: rtl/aib_rx_word_aligner.sv
// AIB receive word aligner: takes the retimed DDR bit pair each cycle,
// hunts for the alignment marker at both bit offsets, verifies it on
// consecutive word boundaries and then emits aligned words.
// Optional feature: define AIB_RX_ALIGN_RELOCK_CNT_EN to add o_relock_cnt,
// a saturating count of exits from the locked state.
module aib_rx_word_aligner
    import aib_rx_align_pkg::*;
#(
    parameter int WORD_W   = AIB_RX_WORD_W,
    parameter int LOCK_CNT = AIB_RX_LOCK_CNT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              c_align_en,
    input  logic [WORD_W-1:0] c_marker,
    input  logic              i_realign,
    input  logic              i_rx_data0,
    input  logic              i_rx_data1,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_locked,
    output logic              o_bit_slip
`ifdef AIB_RX_ALIGN_RELOCK_CNT_EN
    ,
    output logic [7:0]        o_relock_cnt
`endif
);

    localparam int HALF = WORD_W / 2;
    localparam int PH_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(HALF - 1);
    localparam logic [3:0]      LOCK_TGT = 4'(LOCK_CNT);
    localparam bit              DIRECT_LOCK = (LOCK_CNT == 1);

    align_state_t      state_reg, state_next;
    logic [WORD_W-2:0] hist_reg;
    logic [PH_W-1:0]   phase_reg, phase_next;
    logic [3:0]        hit_reg, hit_next;
    logic              slip_reg, slip_next;
    logic              valid_reg, valid_next;
    logic [WORD_W-1:0] data_reg;

    // Previous WORD_W-1 bits plus the current pair: WORD_W+1 bits of stream
    logic [WORD_W:0]   window;
    logic [WORD_W-1:0] sel_window;
    logic              even_hit, odd_hit, sel_hit, boundary;

    assign window     = {i_rx_data1, i_rx_data0, hist_reg};
    assign sel_window = slip_reg ? window[WORD_W-1:0] : window[WORD_W:1];
    assign sel_hit    = slip_reg ? odd_hit : even_hit;
    assign boundary   = (phase_reg == PH_LAST);

    aib_rx_marker_match #(
        .WORD_W (WORD_W)
    ) u_match (
        .window   (window),
        .marker   (c_marker),
        .even_hit (even_hit),
        .odd_hit  (odd_hit)
    );

    // Next-state logic: enable low dominates, then realign, then normal flow
    always_comb begin
        state_next = state_reg;
        phase_next = boundary ? '0 : phase_reg + PH_W'(1);
        hit_next   = hit_reg;
        slip_next  = slip_reg;
        valid_next = 1'b0;
        if (!c_align_en) begin
            state_next = ST_IDLE;
            hit_next   = '0;
            phase_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_HUNT;
                    hit_next   = '0;
                    phase_next = '0;
                end
                ST_HUNT: begin
                    if (i_realign) begin
                        hit_next   = '0;
                        phase_next = '0;
                    end else if (even_hit || odd_hit) begin
                        // Even offset wins a tie
                        slip_next  = !even_hit;
                        phase_next = '0;
                        hit_next   = 4'd1;
                        state_next = DIRECT_LOCK ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (i_realign) begin
                        state_next = ST_HUNT;
                        hit_next   = '0;
                    end else if (boundary) begin
                        if (sel_hit) begin
                            hit_next = hit_reg + 4'd1;
                            if (hit_reg + 4'd1 == LOCK_TGT) begin
                                state_next = ST_LOCKED;
                            end
                        end else begin
                            state_next = ST_HUNT;
                            hit_next   = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (i_realign) begin
                        state_next = ST_HUNT;
                        hit_next   = '0;
                    end else if (boundary) begin
                        valid_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, history and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            hist_reg  <= '0;
            phase_reg <= '0;
            hit_reg   <= '0;
            slip_reg  <= 1'b0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hist_reg  <= window[WORD_W:2];
            phase_reg <= phase_next;
            hit_reg   <= hit_next;
            slip_reg  <= slip_next;
            valid_reg <= valid_next;
            if (valid_next) begin
                data_reg <= sel_window;
            end
        end
    end

    assign o_data     = data_reg;
    assign o_valid    = valid_reg;
    assign o_locked   = (state_reg == ST_LOCKED);
    assign o_bit_slip = slip_reg;

`ifdef AIB_RX_ALIGN_RELOCK_CNT_EN
    logic [7:0] relock_cnt_reg;

    // Count every departure from LOCKED, saturating at 255
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            relock_cnt_reg <= '0;
        end else if (state_reg == ST_LOCKED && state_next != ST_LOCKED
                     && relock_cnt_reg != 8'hFF) begin
            relock_cnt_reg <= relock_cnt_reg + 8'd1;
        end
    end

    assign o_relock_cnt = relock_cnt_reg;
`endif

endmodule

// File: tb/tb_aib_rx_word_aligner.sv
// Directed bench for aib_rx_word_aligner (WORD_W=20, LOCK_CNT=4).
// Bits are queued in stream order; each tick drives one (data0, data1)
// pair on the falling edge and records outputs seen after the prior
// rising edge. Expected tick offsets below are counted from the tick in
// which c_align_en is first driven high (t0).
module tb_aib_rx_word_aligner;

    localparam int         WORD_W   = 20;
    localparam int         LOCK_CNT = 4;
    localparam logic [19:0] MARKER  = 20'h3C5A7;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        c_align_en;
    logic [19:0] c_marker;
    logic        i_realign;
    logic        i_rx_data0;
    logic        i_rx_data1;
    logic [19:0] o_data;
    logic        o_valid;
    logic        o_locked;
    logic        o_bit_slip;
`ifdef AIB_RX_ALIGN_RELOCK_CNT_EN
    logic [7:0]  o_relock_cnt;
`endif

    always #5 i_clk = ~i_clk;

    aib_rx_word_aligner #(
        .WORD_W   (WORD_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
`ifdef AIB_RX_ALIGN_RELOCK_CNT_EN
        .o_relock_cnt (o_relock_cnt),
`endif
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .c_align_en (c_align_en),
        .c_marker   (c_marker),
        .i_realign  (i_realign),
        .i_rx_data0 (i_rx_data0),
        .i_rx_data1 (i_rx_data1),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_locked   (o_locked),
        .o_bit_slip (o_bit_slip)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          t0;
    int          lock_rise;
    bit          slip_at_rise;
    bit          prev_locked;
    bit          mon_locked;
    bit          bitq[$];
    int          valid_cyc[$];
    logic [19:0] valid_dat[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs, then drive controls and the next bit pair
    task automatic tick(input bit en, input bit rl);
        @(negedge i_clk);
        cyc++;
        mon_locked = o_locked;
        if (o_locked && !prev_locked) begin
            lock_rise    = cyc;
            slip_at_rise = o_bit_slip;
        end
        prev_locked = o_locked;
        if (o_valid) begin
            valid_cyc.push_back(cyc);
            valid_dat.push_back(o_data);
            $display("word tick=%0d data=%05h slip=%0b", cyc, o_data, o_bit_slip);
        end
        c_align_en = en;
        i_realign  = rl;
        if (bitq.size() >= 2) begin
            i_rx_data0 = bitq.pop_front();
            i_rx_data1 = bitq.pop_front();
        end else begin
            i_rx_data0 = 1'b0;
            i_rx_data1 = 1'b0;
        end
    endtask

    task automatic run(input int n, input bit en);
        repeat (n) tick(en, 1'b0);
    endtask

    task automatic push_word(input logic [19:0] w);
        for (int i = 0; i < 20; i++) bitq.push_back(w[i]);
    endtask

    task automatic push_fill(input int n, input bit v);
        for (int i = 0; i < n; i++) bitq.push_back(v);
    endtask

    task automatic clear_log();
        valid_cyc.delete();
        valid_dat.delete();
        lock_rise = -1;
    endtask

    task automatic do_reset(input logic [19:0] mk);
        i_rst_n  = 1'b0;
        c_marker = mk;
        bitq.delete();
        clear_log();
        repeat (3) tick(1'b0, 1'b0);
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n    = 1'b0;
        c_align_en = 1'b0;
        c_marker   = MARKER;
        i_realign  = 1'b0;
        i_rx_data0 = 1'b0;
        i_rx_data1 = 1'b0;
        prev_locked = 1'b0;

        // Reset state
        do_reset(MARKER);
        check_val("rst_data", o_data, 0);
        check_val("rst_valid", o_valid, 0);
        check_val("rst_locked", o_locked, 0);
        check_val("rst_slip", o_bit_slip, 0);

        // Even offset: 4 zero pairs then markers; 1st hit P13, 4th hit P43
        do_reset(MARKER);
        push_fill(8, 1'b0);
        repeat (8) push_word(MARKER);
        t0 = cyc + 1;
        run(86, 1'b1);
        check_val("even_lock_tick", lock_rise - t0, 44);
        check_val("even_slip", slip_at_rise, 0);
        check_val("even_nvalid", valid_cyc.size(), 4);
        for (int i = 0; i < valid_cyc.size(); i++) begin
            check_val($sformatf("even_vtick%0d", i), valid_cyc[i] - t0, 54 + 10 * i);
            check_val($sformatf("even_vdata%0d", i), valid_dat[i], MARKER);
        end
        check_val("hold_valid", o_valid, 0);
        check_val("hold_data", o_data, MARKER);

        // One-bit delay: odd offset, lock at 45, payload words at 55 and 65
        do_reset(MARKER);
        push_fill(9, 1'b0);
        repeat (4) push_word(MARKER);
        push_word(20'h12345);
        push_word(20'hABCDE);
        push_fill(20, 1'b0);
        t0 = cyc + 1;
        run(67, 1'b1);
        check_val("odd_lock_tick", lock_rise - t0, 45);
        check_val("odd_slip", slip_at_rise, 1);
        check_val("odd_nvalid", valid_cyc.size(), 2);
        if (valid_cyc.size() == 2) begin
            check_val("odd_vtick0", valid_cyc[0] - t0, 55);
            check_val("odd_vdata0", valid_dat[0], 20'h12345);
            check_val("odd_vtick1", valid_cyc[1] - t0, 65);
            check_val("odd_vdata1", valid_dat[1], 20'hABCDE);
        end

        // Corrupt 3rd marker: miss at P33, fresh hits P43..P73, lock at 74
        do_reset(MARKER);
        push_fill(8, 1'b0);
        push_word(MARKER);
        push_word(MARKER);
        push_word(MARKER ^ 20'h00001);
        repeat (5) push_word(MARKER);
        t0 = cyc + 1;
        run(76, 1'b1);
        check_val("corrupt_lock_tick", lock_rise - t0, 74);
        check_val("corrupt_nvalid", valid_cyc.size(), 0);

        // Realign in LOCKED at P48; rehunt hits P53..P83, lock at 84
        do_reset(MARKER);
        push_fill(8, 1'b0);
        repeat (8) push_word(MARKER);
        t0 = cyc + 1;
        run(48, 1'b1);
        tick(1'b1, 1'b1);
        check_val("realign_pre_locked", mon_locked, 1);
        tick(1'b1, 1'b0);
        check_val("realign_post_locked", mon_locked, 0);
        run(36, 1'b1);
        check_val("realign_relock_tick", lock_rise - t0, 84);
        check_val("realign_nvalid", valid_cyc.size(), 0);
`ifdef AIB_RX_ALIGN_RELOCK_CNT_EN
        check_val("relock_cnt_realign", o_relock_cnt, 1);
`endif

        // Reset mid-word while locked at odd offset
        do_reset(MARKER);
        push_fill(9, 1'b0);
        repeat (14) push_word(MARKER);
        t0 = cyc + 1;
        run(58, 1'b1);
        check_val("mid_lock_tick", lock_rise - t0, 45);
        check_val("mid_slip", slip_at_rise, 1);
        check_val("mid_nvalid", valid_cyc.size(), 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_val("mid_rst_data", o_data, 0);
        check_val("mid_rst_valid", o_valid, 0);
        check_val("mid_rst_locked", o_locked, 0);
        check_val("mid_rst_slip", o_bit_slip, 0);
        clear_log();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        i_rst_n = 1'b1;
        run(60, 1'b1);
        check_val("mid_relock_tick", lock_rise - t0, 105);
        check_val("mid_relock_slip", slip_at_rise, 1);
        check_val("mid_post_nvalid", valid_cyc.size() > 0, 1);
        if (valid_cyc.size() > 0) begin
            check_val("mid_first_vtick", valid_cyc[0] - t0, 115);
            check_val("mid_first_vdata", valid_dat[0], MARKER);
        end

        // All-ones stream, marker FFFFF: both windows hit at once, even wins
        do_reset(20'hFFFFF);
        push_fill(124, 1'b1);
        run(12, 1'b0);
        t0 = cyc + 1;
        run(44, 1'b1);
        check_val("tie_lock_tick", lock_rise - t0, 32);
        check_val("tie_slip", slip_at_rise, 0);
        check_val("tie_nvalid", valid_cyc.size() > 0, 1);
        if (valid_cyc.size() > 0) begin
            check_val("tie_vtick0", valid_cyc[0] - t0, 42);
            check_val("tie_vdata0", valid_dat[0], 20'hFFFFF);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_val("en_low_locked", mon_locked, 0);
`ifdef AIB_RX_ALIGN_RELOCK_CNT_EN
        check_val("relock_cnt_en_low", o_relock_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
